// File: rtl/mix_columns_iter_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mix_columns_iter_pkg
// Brief    : Shared constants and types for the iterative MixColumns stage.
// Revision : 1.0 - initial release
// ============================================================================
package mix_columns_iter_pkg;

   // Column geometry of the AES state
   localparam int AES_COLW = 32;
   localparam int AES_NCOL = 4;

   // Low byte of the GF(2^8) reduction polynomial x^8+x^4+x^3+x+1
   localparam logic [7:0] AES_POLY = 8'h1b;

   // Control FSM encoding
   typedef logic [1:0] fsm_state_t;
   localparam fsm_state_t ST_IDLE = 2'd0;
   localparam fsm_state_t ST_BUSY = 2'd1;
   localparam fsm_state_t ST_DONE = 2'd2;

   typedef logic [AES_COLW-1:0] column_t;

endpackage
`default_nettype wire

// File: rtl/mix_single_column.sv
`default_nettype none
// ============================================================================
// Module   : mix_single_column
// Brief    : Combinational MixColumns / InvMixColumns of one 32-bit column.
//            Byte 0 (row 0) is the MSB of the column.
// Revision : 1.0 - initial release
// ============================================================================
module mix_single_column
   import mix_columns_iter_pkg::*;
(
   input  logic [AES_COLW-1:0] col_in,
   input  logic                inv,
   output logic [AES_COLW-1:0] col_out
);

   logic [7:0] w_a   [4];
   logic [7:0] w_x2  [4];
   logic [7:0] w_x4  [4];
   logic [7:0] w_x8  [4];
   logic [7:0] w_m09 [4];
   logic [7:0] w_m0b [4];
   logic [7:0] w_m0d [4];
   logic [7:0] w_m0e [4];
   logic [7:0] w_fwd [4];
   logic [7:0] w_inv [4];

   // Per byte: x2, x4, x8 chain and the four inverse-mix multiples
   for (genvar i = 0; i < 4; i++) begin : g_byte
      assign w_a[i] = col_in[AES_COLW-1-8*i -: 8];

      xtime u_x2 (.a_i(w_a[i]),  .y_o(w_x2[i]));
      xtime u_x4 (.a_i(w_x2[i]), .y_o(w_x4[i]));
      xtime u_x8 (.a_i(w_x4[i]), .y_o(w_x8[i]));

      assign w_m09[i] = w_x8[i] ^ w_a[i];
      assign w_m0b[i] = w_x8[i] ^ w_x2[i] ^ w_a[i];
      assign w_m0d[i] = w_x8[i] ^ w_x4[i] ^ w_a[i];
      assign w_m0e[i] = w_x8[i] ^ w_x4[i] ^ w_x2[i];
   end

   // Output row r uses coefficients rotated by r positions
   for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int J1 = (r + 1) % 4;
      localparam int J2 = (r + 2) % 4;
      localparam int J3 = (r + 3) % 4;

      assign w_fwd[r] = w_x2[r] ^ (w_x2[J1] ^ w_a[J1]) ^ w_a[J2] ^ w_a[J3];
      assign w_inv[r] = w_m0e[r] ^ w_m0b[J1] ^ w_m0d[J2] ^ w_m09[J3];
      assign col_out[AES_COLW-1-8*r -: 8] = inv ? w_inv[r] : w_fwd[r];
   end

endmodule
`default_nettype wire

// File: rtl/xtime.sv
`default_nettype none
// ============================================================================
// Module   : xtime
// Brief    : Multiply one byte by x (0x02) in GF(2^8), reducing by 0x11b.
// Revision : 1.0 - initial release
// ============================================================================
module xtime
   import mix_columns_iter_pkg::*;
(
   input  logic [7:0] a_i,
   output logic [7:0] y_o
);

   // Shift left and fold the carried-out bit back through the polynomial
   assign y_o = {a_i[6:0], 1'b0} ^ (a_i[7] ? AES_POLY : 8'h00);

endmodule
`default_nettype wire

// File: rtl/mix_columns_iter.sv
`default_nettype none
// ============================================================================
// Module   : mix_columns_iter
// Brief    : Iterative MixColumns / InvMixColumns. Accepts one 128-bit state,
//            transforms one column per clock through a single shared column
//            datapath, then holds the result until downstream takes it.
// Revision : 1.0 - initial release
// ============================================================================
module mix_columns_iter
   import mix_columns_iter_pkg::*;
#(
   parameter int NCOL = AES_NCOL
)
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_inv,
   input  logic [NCOL*AES_COLW-1:0] in_state,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [NCOL*AES_COLW-1:0] out_state,
   output logic                     busy
);

   localparam int SW = NCOL * AES_COLW;

   fsm_state_t    state_q, state_d;
   logic [SW-1:0] data_q,  data_d;
   logic [1:0]    col_q,   col_d;
   logic          inv_q,   inv_d;
   column_t       w_col_in;
   column_t       w_col_out;

   // Select the column currently being processed
   always_comb begin
      w_col_in = '0;
      for (int c = 0; c < NCOL; c++) begin
         if (col_q == c[1:0]) begin
            w_col_in = data_q[SW-1-AES_COLW*c -: AES_COLW];
         end
      end
   end

   mix_single_column u_col (
      .col_in  (w_col_in),
      .inv     (inv_q),
      .col_out (w_col_out)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: four BUSY edges, then hold in DONE until taken
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (in_valid)       state_d = ST_BUSY;
         ST_BUSY: if (col_q == 2'd3)  state_d = ST_DONE;
         ST_DONE: if (out_ready)      state_d = ST_IDLE;
         default:                     state_d = ST_IDLE;
      endcase
   end

   // FSM outputs, decoded from registered state only
   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_DONE);
      busy      = (state_q == ST_BUSY) || (state_q == ST_DONE);
      out_state = data_q;
   end

   // Datapath next state: load on accept, write back one column per BUSY edge
   always_comb begin
      data_d = data_q;
      col_d  = col_q;
      inv_d  = inv_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               data_d = in_state;
               inv_d  = in_inv;
               col_d  = 2'd0;
            end
         end
         ST_BUSY: begin
            for (int c = 0; c < NCOL; c++) begin
               if (col_q == c[1:0]) begin
                  data_d[SW-1-AES_COLW*c -: AES_COLW] = w_col_out;
               end
            end
            // 3 -> 0 wrap leaves col at 0 for the next block
            col_d = col_q + 2'd1;
         end
         default: ;
      endcase
   end

   // Datapath registers; reset discards any in-flight block
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         col_q  <= 2'd0;
         inv_q  <= 1'b0;
      end else begin
         data_q <= data_d;
         col_q  <= col_d;
         inv_q  <= inv_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mix_columns_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mix_columns_iter
// Brief    : Self-checking bench for mix_columns_iter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mix_columns_iter;

   localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
   localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
   localparam logic [127:0] KC_IN    = 128'hdb135345f20a225c01010101c6c6c6c6;
   localparam logic [127:0] KC_OUT   = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;

   logic         clk       = 1'b0;
   logic         rst_n     = 1'b0;
   logic         in_valid  = 1'b0;
   logic         in_inv    = 1'b0;
   logic         out_ready = 1'b0;
   logic [127:0] in_state  = '0;
   logic         in_ready;
   logic         out_valid;
   logic         busy;
   logic [127:0] out_state;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mix_columns_iter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_inv    (in_inv),
      .in_state  (in_state),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_state (out_state),
      .busy      (busy)
   );

   // Generic GF(2^8) multiply by shift-and-add
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   // Whole-state matrix product with the circulant (Inv)MixColumns matrix
   function automatic logic [127:0] mix_model(input logic [127:0] s, input logic inv);
      logic [7:0]   coef [4];
      logic [7:0]   a    [4];
      logic [7:0]   b;
      logic [127:0] r;
      if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int j = 0; j < 4; j++) a[j] = s[127-32*c-8*j -: 8];
         for (int row = 0; row < 4; row++) begin
            b = 8'h00;
            for (int j = 0; j < 4; j++) b = b ^ gmul(coef[(j - row + 4) % 4], a[j]);
            r[127-32*c-8*row -: 8] = b;
         end
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Transaction monitor: tracks the one outstanding block and its expected result
   int           cyc      = 0;
   logic         pend     = 1'b0;
   int           acc_cyc  = 0;
   logic [127:0] pend_exp = '0;
   int           acc_log [$];
   logic [127:0] rel_log [$];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend <= 1'b0;
      end else begin
         cyc <= cyc + 1;
         if (pend && out_valid && out_ready) begin
            pend <= 1'b0;
            rel_log.push_back(out_state);
         end else if (!pend && in_valid && in_ready) begin
            pend     <= 1'b1;
            acc_cyc  <= cyc + 1;
            acc_log.push_back(cyc + 1);
            pend_exp <= mix_model(in_state, in_inv);
         end
      end
   end

   // Compare process: every cycle out of reset, handshake/busy/result vs model
   initial begin
      logic exp_valid;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            exp_valid = pend && (cyc >= acc_cyc + 4);
            chk("cyc_in_ready",  128'(in_ready),  128'(!pend));
            chk("cyc_out_valid", 128'(out_valid), 128'(exp_valid));
            chk("cyc_busy",      128'(busy),      128'(pend));
            if (exp_valid) chk("cyc_out_state", out_state, pend_exp);
         end
      end
   end

   // Present a block and return at the falling edge after it was accepted
   task automatic do_accept(input logic [127:0] st, input logic inv);
      bit ok;
      ok       = 1'b0;
      in_valid = 1'b1;
      in_state = st;
      in_inv   = inv;
      for (int t = 0; t < 20; t++) begin
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         errors++;
         $display("FAIL accept_timeout: got in_ready=0 expected 1 within 20 cycles");
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_state = {$urandom, $urandom, $urandom, $urandom};
      in_inv   = 1'($urandom);
   endtask

   // Full transaction with literal result, optional output backpressure
   task automatic run_block(input logic [127:0] st, input logic inv,
                            input logic [127:0] lit, input int hold);
      int n;
      do_accept(st, inv);
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("latency", 128'(n), 128'(4));
      chk("result", out_state, lit);
      for (int h = 0; h < hold; h++) begin
         in_valid = (h == 3);
         in_state = ~st;
         @(negedge clk);
         chk("bp_state", out_state, lit);
         chk("bp_in_ready", 128'(in_ready), 128'(0));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("release_in_ready", 128'(in_ready), 128'(1));
   endtask

   initial begin
      logic [127:0] bb_in  [3];
      logic [127:0] bb_out [3];
      logic         bb_inv [3];
      int           base;
      int           na;
      int           t;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_in_ready",  128'(in_ready),  128'(1));
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_busy",      128'(busy),      128'(0));
      chk("rst_out_state", out_state,       128'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Forward / inverse, FIPS-197 and known columns
      run_block(FIPS_IN,  1'b0, FIPS_OUT, 0);
      run_block(FIPS_OUT, 1'b1, FIPS_IN,  0);
      run_block(KC_IN,    1'b0, KC_OUT,   0);
      run_block(KC_OUT,   1'b1, KC_IN,    0);

      // Backpressure with an ignored in_valid pulse
      run_block(FIPS_IN, 1'b0, FIPS_OUT, 10);

      // Reset during the second BUSY cycle
      do_accept(KC_IN, 1'b0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
      chk("mid_rst_in_ready",  128'(in_ready),  128'(1));
      chk("mid_rst_busy",      128'(busy),      128'(0));
      chk("mid_rst_out_state", out_state,       128'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_block(KC_IN, 1'b0, KC_OUT, 0);

      // Back-to-back with in_valid held and out_ready tied high
      bb_in  = '{FIPS_IN,  KC_IN,  FIPS_OUT};
      bb_inv = '{1'b0,     1'b0,   1'b1};
      bb_out = '{FIPS_OUT, KC_OUT, FIPS_IN};
      base   = rel_log.size();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int b = 0; b < 3; b++) begin
         in_state = bb_in[b];
         in_inv   = bb_inv[b];
         t = 0;
         while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
         end
         if (t >= 20) begin
            errors++;
            $display("FAIL b2b_accept_timeout: got in_ready=0 expected 1 within 20 cycles");
         end
         @(posedge clk);
         @(negedge clk);
      end
      in_valid = 1'b0;
      t = 0;
      while (rel_log.size() < base + 3 && t < 30) begin
         @(negedge clk);
         t++;
      end
      out_ready = 1'b0;
      chk("b2b_release_count", 128'(rel_log.size() - base), 128'(3));
      if (rel_log.size() >= base + 3) begin
         for (int b = 0; b < 3; b++) chk("b2b_order", rel_log[base+b], bb_out[b]);
      end
      na = acc_log.size();
      chk("b2b_spacing_1", 128'(acc_log[na-2] - acc_log[na-3]), 128'(6));
      chk("b2b_spacing_2", 128'(acc_log[na-1] - acc_log[na-2]), 128'(6));

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global time bound
   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
